mips_state_dump: RTL and testbench
==================================

MIPS_STATE_DUMP -- requirements
Module: mips_state_dump

Interface
REQ-001 Parameter DATA_W, default 32, width of every dumped word and of the stream output.
REQ-002 Parameter DMEM_DEPTH, default 8192, number of data-memory words dumped; a power of two, at least 2.
REQ-003 Parameter NREGS, default 32, number of register-file entries dumped; a power of two, at least 2.
REQ-004 Parameter TIMEOUT_CYC, default 100, watchdog trigger count in cycles; 0 disables the watchdog.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 halted_i  in  1  CPU halted flag.
REQ-008 start_i  in  1  manual dump-trigger pulse.
REQ-009 clear_i  in  1  clears done_o and re-arms the block.
REQ-010 pc_i  in  DATA_W  current CPU program counter.
REQ-011 mem_addr_o  out  log2(DMEM_DEPTH)  data-memory read address.
REQ-012 mem_rd_o  out  1  data-memory read strobe.
REQ-013 mem_rdata_i  in  DATA_W  memory read data, valid exactly 1 cycle after mem_rd_o.
REQ-014 reg_addr_o  out  log2(NREGS)  register-file read address.
REQ-015 reg_rd_o  out  1  register-file read strobe.
REQ-016 reg_rdata_i  in  DATA_W  register read data, valid exactly 1 cycle after reg_rd_o.
REQ-017 dump_valid_o  out  1  stream word valid.
REQ-018 dump_ready_i  in  1  stream sink ready.
REQ-019 dump_data_o  out  DATA_W  stream word.
REQ-020 dump_sec_o  out  2  section tag: 0 = MEM, 1 = REG, 2 = PC.
REQ-021 dump_last_o  out  1  asserted on the final word (PC).
REQ-022 busy_o  out  1  dump in progress.
REQ-023 done_o  out  1  sticky dump-complete flag.

Function
REQ-024 The FSM SHALL have the states ARM, RD_MEM, RD_REG, RD_PC, DRAIN and DONE.
REQ-025 In ARM the block SHALL trigger on the first of: a start_i pulse, a 0->1 edge of halted_i, or the watchdog reaching TIMEOUT_CYC cycles counted since leaving reset or clear.
REQ-026 Simultaneous trigger sources SHALL produce exactly one dump.
REQ-027 Triggers arriving outside ARM SHALL be ignored.
REQ-028 The first read strobe SHALL be issued in the cycle after the trigger is sampled; with dump_ready_i held high, dump_valid_o SHALL rise 2 cycles after the trigger.
REQ-029 Words SHALL stream in this fixed order: MEM 0..DMEM_DEPTH-1, then REG 0..NREGS-1, then the pc_i value sampled at trigger; total DMEM_DEPTH+NREGS+1 words.
REQ-030 A word transfers when dump_valid_o and dump_ready_i are both high; with dump_valid_o high and dump_ready_i low, data, section and last SHALL remain stable.
REQ-031 A read SHALL be issued only when (buffered words + reads in flight) < 2, so no read data is ever lost.
REQ-032 With dump_ready_i held high, sustained throughput SHALL be one word per cycle, including across the MEM->REG and REG->PC boundaries.
REQ-033 The address counters SHALL stop at their last index, with no wrap-around.
REQ-034 The FSM SHALL move RD_MEM->RD_REG after issuing address DMEM_DEPTH-1, RD_REG->RD_PC after issuing address NREGS-1, RD_PC->DRAIN after enqueuing the PC, and DRAIN->DONE after the last-word transfer.
REQ-035 busy_o SHALL be high from the cycle after the trigger through the last-word transfer.
REQ-036 done_o SHALL be set in the cycle after the last-word transfer and hold until clear_i.
REQ-037 clear_i in DONE SHALL move the FSM to ARM and restart the watchdog.
REQ-038 clear_i in any other state SHALL be ignored.

Reset
REQ-039 rst_n low SHALL immediately force state ARM, all counters 0, the buffer empty, and every output 0.
REQ-040 Reset asserted mid-dump SHALL abandon the dump with no further strobes issued.
REQ-041 After rst_n deasserts, the first trigger SHALL be sampled no earlier than the first rising clock edge.

Structure
REQ-042 A shared package mips_dbg_pkg SHALL hold the FSM state enum, the section-tag constants (SEC_MEM, SEC_REG, SEC_PC) and the default parameter values.
REQ-043 One sub-module, dump_skid_buf, SHALL implement the 2-entry valid/ready buffer carrying data, section and last, and report its occupancy.

Verification
REQ-044 DMEM_DEPTH=4, NREGS=2, memory 0x10..0x13, registers 0xA0/0xA1, pc_i=0x2C, start_i pulse, ready held high -> exactly 7 words 0x10,0x11,0x12,0x13,0xA0,0xA1,0x2C; sections 0,0,0,0,1,1,2; last only on 0x2C; first valid 2 cycles after start_i; done_o high 1 cycle after the last word.
REQ-045 Same setup with dump_ready_i toggling every other cycle -> identical word sequence, data stable while stalled, and never more than 2 reads outstanding.
REQ-046 TIMEOUT_CYC=10, no other trigger -> dump starts exactly 10 cycles after reset release.
REQ-047 halted_i rising in the same cycle as start_i -> one 7-word dump; a halted_i edge during the dump causes no second dump after done_o.
REQ-048 rst_n pulsed low after the 3rd word -> all outputs 0 asynchronously; after release, start_i -> full 7-word dump beginning at address 0.
REQ-049 clear_i in DONE followed by start_i -> second complete dump; clear_i during busy_o -> no effect.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the debug state-dump block.
package mips_dbg_pkg;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DMEM_DEPTH  = 8192;
  localparam int DEF_NREGS       = 32;
  localparam int DEF_TIMEOUT_CYC = 100;

  typedef enum logic [2:0] {
    ARM, RD_MEM, RD_REG, RD_PC, DRAIN, DONE
  } dump_state_t;

  localparam logic [1:0] SEC_MEM = 2'd0;
  localparam logic [1:0] SEC_REG = 2'd1;
  localparam logic [1:0] SEC_PC  = 2'd2;
endpackage

// File: rtl/dump_skid_buf.sv
// Two-entry valid/ready buffer for dump words; head entry drives the stream.
module dump_skid_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sec,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sec,
  output logic              out_last,
  output logic [1:0]        count
);
  localparam int EW = DATA_W + 3;

  logic [EW-1:0] e0, e1, in_vec;
  logic          pop;

  assign in_vec    = {in_last, in_sec, in_data};
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign {out_last, out_sec, out_data} = e0;

  // Producer never pushes into a full buffer, so no overflow guard here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0    <= '0;
      e1    <= '0;
      count <= 2'd0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= in_vec;
          else               e1 <= in_vec;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) e0 <= in_vec;
          else begin
            e0 <= e1;
            e1 <= in_vec;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mips_state_dump.sv
// Streams data memory, register file and PC out of a halted MIPS core
// as one valid/ready word stream with section tags.
module mips_state_dump
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DMEM_DEPTH  = DEF_DMEM_DEPTH,
  parameter int NREGS       = DEF_NREGS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int MAW = $clog2(DMEM_DEPTH),
  localparam int RAW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halted_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic [MAW-1:0]    mem_addr_o,
  output logic              mem_rd_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [RAW-1:0]    reg_addr_o,
  output logic              reg_rd_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [1:0]        dump_sec_o,
  output logic              dump_last_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam logic [MAW-1:0] MEM_LAST = MAW'(DMEM_DEPTH - 1);
  localparam logic [RAW-1:0] REG_LAST = RAW'(NREGS - 1);

  dump_state_t       state, nxt;
  logic [MAW-1:0]    mem_cnt;
  logic [RAW-1:0]    reg_cnt;
  logic [31:0]       wd_cnt;
  logic              halted_q;
  logic [DATA_W-1:0] pc_q;
  logic              infl_vld, infl_last;
  logic [1:0]        infl_sec;
  logic [1:0]        buf_cnt;
  logic [2:0]        occ;
  logic              pop, slot, trig, wd_hit, pc_iss;
  logic [DATA_W-1:0] push_data;

  assign wd_hit = (TIMEOUT_CYC != 0) && (wd_cnt == 32'(TIMEOUT_CYC - 1));
  assign trig   = start_i | (halted_i & ~halted_q) | wd_hit;
  assign pop    = dump_valid_o & dump_ready_i;
  // A word leaving this cycle frees its slot, which keeps one word per cycle.
  assign occ    = 3'(buf_cnt) + 3'(infl_vld) - 3'(pop);
  assign slot   = (occ < 3'd2);

  assign mem_addr_o = mem_cnt;
  assign reg_addr_o = reg_cnt;
  assign busy_o     = (state == RD_MEM) || (state == RD_REG) ||
                      (state == RD_PC)  || (state == DRAIN);
  assign done_o     = (state == DONE);

  always_comb begin
    nxt      = state;
    mem_rd_o = 1'b0;
    reg_rd_o = 1'b0;
    pc_iss   = 1'b0;
    case (state)
      ARM:    if (trig) nxt = RD_MEM;
      RD_MEM: begin
        mem_rd_o = slot;
        if (slot && mem_cnt == MEM_LAST) nxt = RD_REG;
      end
      RD_REG: begin
        reg_rd_o = slot;
        if (slot && reg_cnt == REG_LAST) nxt = RD_PC;
      end
      RD_PC: begin
        pc_iss = slot;
        if (slot) nxt = DRAIN;
      end
      DRAIN:  if (pop && dump_last_o) nxt = DONE;
      DONE:   if (clear_i) nxt = ARM;
      default: nxt = ARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARM;
      mem_cnt   <= '0;
      reg_cnt   <= '0;
      wd_cnt    <= '0;
      halted_q  <= 1'b0;
      pc_q      <= '0;
      infl_vld  <= 1'b0;
      infl_sec  <= SEC_MEM;
      infl_last <= 1'b0;
    end else begin
      state    <= nxt;
      halted_q <= halted_i;
      // Watchdog only runs while armed; leaving ARM restarts it.
      if (state == ARM) begin
        if (wd_cnt != '1) wd_cnt <= wd_cnt + 32'd1;
      end else begin
        wd_cnt <= '0;
      end
      if (state == ARM && trig) begin
        mem_cnt <= '0;
        reg_cnt <= '0;
        pc_q    <= pc_i;
      end
      if (mem_rd_o && mem_cnt != MEM_LAST) mem_cnt <= mem_cnt + MAW'(1);
      if (reg_rd_o && reg_cnt != REG_LAST) reg_cnt <= reg_cnt + RAW'(1);
      // The PC rides the same one-cycle slot as a read so ordering is kept.
      infl_vld  <= mem_rd_o | reg_rd_o | pc_iss;
      infl_sec  <= reg_rd_o ? SEC_REG : (pc_iss ? SEC_PC : SEC_MEM);
      infl_last <= pc_iss;
    end
  end

  always_comb begin
    push_data = mem_rdata_i;
    case (infl_sec)
      SEC_REG: push_data = reg_rdata_i;
      SEC_PC:  push_data = pc_q;
      default: push_data = mem_rdata_i;
    endcase
  end

  dump_skid_buf #(.DATA_W(DATA_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (infl_vld),
    .in_data   (push_data),
    .in_sec    (infl_sec),
    .in_last   (infl_last),
    .out_valid (dump_valid_o),
    .out_ready (dump_ready_i),
    .out_data  (dump_data_o),
    .out_sec   (dump_sec_o),
    .out_last  (dump_last_o),
    .count     (buf_cnt)
  );
endmodule

// File: tb/tb_mips_state_dump.sv
// Directed scoreboard bench for mips_state_dump (4 mem words, 2 regs, watchdog 10).
module tb_mips_state_dump;
  localparam int MD = 4;
  localparam int NR = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        halted_i = 1'b0, start_i = 1'b0, clear_i = 1'b0;
  logic [31:0] pc_i = 32'h2C;
  logic [1:0]  mem_addr_o;
  logic        mem_rd_o;
  logic [31:0] mem_rdata_i;
  logic [0:0]  reg_addr_o;
  logic        reg_rd_o;
  logic [31:0] reg_rdata_i;
  logic        dump_valid_o, dump_ready_i, dump_last_o, busy_o, done_o;
  logic [31:0] dump_data_o;
  logic [1:0]  dump_sec_o;
  logic        rdy_toggle = 1'b0, rdy_ph = 1'b0;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
    logic        l;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0, words = 0, w0 = 0, issued = 0, popped_rd = 0, n = 0;
  logic        prev_stall = 1'b0, prev_last = 1'b0;
  logic [34:0] held = '0;

  assign dump_ready_i = rdy_toggle ? rdy_ph : 1'b1;

  mips_state_dump #(
    .DATA_W(32), .DMEM_DEPTH(MD), .NREGS(NR), .TIMEOUT_CYC(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .halted_i(halted_i), .start_i(start_i),
    .clear_i(clear_i), .pc_i(pc_i),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_rdata_i(mem_rdata_i),
    .reg_addr_o(reg_addr_o), .reg_rd_o(reg_rd_o), .reg_rdata_i(reg_rdata_i),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_data_o(dump_data_o), .dump_sec_o(dump_sec_o), .dump_last_o(dump_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Memory/regfile models: data appears exactly one cycle after the strobe.
  always @(posedge clk) begin
    rdy_ph      <= ~rdy_ph;
    mem_rdata_i <= mem_rd_o ? 32'h10 + 32'(mem_addr_o) : 32'hDEADBEEF;
    reg_rdata_i <= reg_rd_o ? 32'hA0 + 32'(reg_addr_o) : 32'hDEADBEEF;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_dump(input logic [31:0] pc);
    for (int i = 0; i < MD; i++) q.push_back('{d: 32'h10 + 32'(i), s: 2'd0, l: 1'b0});
    for (int i = 0; i < NR; i++) q.push_back('{d: 32'hA0 + 32'(i), s: 2'd1, l: 1'b0});
    q.push_back('{d: pc, s: 2'd2, l: 1'b1});
  endtask

  task automatic outs_zero(input string tag);
    chk(tag, 64'({mem_addr_o, mem_rd_o, reg_addr_o, reg_rd_o, dump_valid_o,
                  dump_data_o, dump_sec_o, dump_last_o, busy_o, done_o}), 64'd0);
  endtask

  task automatic wait_done(input string tag);
    n = 0;
    while (!done_o && n < 200) begin step(); n++; end
    chk({tag, "_done"}, 64'(done_o), 64'd1);
    chk({tag, "_words"}, 64'(words - w0), 64'd7);
    chk({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("clear_rearm", 64'(done_o), 64'd0);
  endtask

  // Stream monitor: scoreboard pop, stall stability, outstanding reads, done timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_last  = 1'b0;
      issued     = 0;
      popped_rd  = 0;
    end else begin
      if (prev_last) begin
        chk("done_after_last", 64'(done_o), 64'd1);
        chk("busy_after_last", 64'(busy_o), 64'd0);
      end
      if (prev_stall)
        chk("stall_hold", 64'({dump_valid_o, dump_last_o, dump_sec_o, dump_data_o}),
            64'({1'b1, held}));
      if (mem_rd_o || reg_rd_o) issued++;
      if (dump_valid_o && dump_ready_i) begin
        chk("word_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("word", 64'({dump_last_o, dump_sec_o, dump_data_o}), 64'({e.l, e.s, e.d}));
        end
        words++;
        if (dump_sec_o != 2'd2) popped_rd++;
      end
      if (busy_o) chk("outstanding_le2", 64'((issued - popped_rd) <= 2), 64'd1);
      prev_stall = dump_valid_o && !dump_ready_i;
      held       = {dump_last_o, dump_sec_o, dump_data_o};
      prev_last  = dump_valid_o && dump_ready_i && dump_last_o;
    end
  end

  initial begin
    // Reset state, then the watchdog fires on the 10th edge after release.
    #1;
    outs_zero("reset_outs");
    push_dump(32'h2C);
    w0 = words;
    step();
    step();
    rst_n = 1'b1;
    repeat (9) begin
      step();
      chk("wd_idle", 64'(busy_o), 64'd0);
    end
    step();
    chk("wd_start_busy", 64'(busy_o), 64'd1);
    chk("wd_start_rd", 64'(mem_rd_o), 64'd1);
    wait_done("wd");

    // Manual start with ready high; pc changed after trigger must not leak.
    do_clear();
    push_dump(32'h2C);
    w0 = words;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    pc_i = 32'h99;
    chk("first_busy", 64'(busy_o), 64'd1);
    chk("first_rd", 64'(mem_rd_o), 64'd1);
    chk("first_addr", 64'(mem_addr_o), 64'd0);
    chk("valid_t0", 64'(dump_valid_o), 64'd0);
    step();
    chk("valid_t1", 64'(dump_valid_o), 64'd0);
    step();
    chk("valid_t2", 64'(dump_valid_o), 64'd1);
    chk("first_data", 64'(dump_data_o), 64'h10);
    wait_done("basic");
    pc_i = 32'h2C;

    // Ready toggling, plus clear while busy.
    do_clear();
    rdy_toggle = 1'b1;
    push_dump(32'h2C);
    w0 = words;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("clear_busy_ignored", 64'(busy_o), 64'd1);
    wait_done("toggle");
    rdy_toggle = 1'b0;

    // Simultaneous start + halted edge, and a halted edge mid-dump.
    do_clear();
    push_dump(32'h2C);
    w0 = words;
    start_i  = 1'b1;
    halted_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (2) step();
    halted_i = 1'b0;
    step();
    halted_i = 1'b1;
    step();
    wait_done("simul");
    repeat (15) step();
    chk("no_second_done", 64'(done_o), 64'd1);
    chk("no_second_busy", 64'(busy_o), 64'd0);
    chk("no_second_words", 64'(words - w0), 64'd7);
    halted_i = 1'b0;

    // Reset after the third word, then a full restart from address 0.
    do_clear();
    push_dump(32'h2C);
    w0 = words;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    n = 0;
    while ((words - w0) < 3 && n < 50) begin step(); n++; end
    chk("three_words", 64'(words - w0), 64'd3);
    rst_n = 1'b0;
    #1;
    outs_zero("midreset_outs");
    q.delete();
    step();
    chk("midreset_no_strobe", 64'({mem_rd_o, reg_rd_o, busy_o}), 64'd0);
    rst_n = 1'b1;
    push_dump(32'h2C);
    w0 = words;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("restart_rd", 64'(mem_rd_o), 64'd1);
    chk("restart_addr", 64'(mem_addr_o), 64'd0);
    wait_done("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
